// File: rtl/int_to_float_seq_pkg.sv
// Shared single-precision constants and the converter state encoding.
// Imported by the sequencer and the round/pack stage.
package int_to_float_seq_pkg;

    localparam int FP_BIAS   = 127;
    localparam int FP_FRAC_W = 23;
    localparam int FP_EXP_W  = 8;

    localparam logic [31:0] FP_POS_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP_NEG_ZERO = 32'h8000_0000;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_NORMALIZE = 2'd1,
        ST_ROUND     = 2'd2,
        ST_DONE      = 2'd3
    } state_t;

endpackage

// File: rtl/int_to_float_seq_round_pack.sv
// Combinational round-to-nearest-even and IEEE-754 packing of a normalized
// 32-bit magnitude whose leading one sits in bit 31.
module fp_round_pack
    import int_to_float_seq_pkg::*;
(
    input  logic        sign_i,
    input  logic [31:0] mag_i,
    input  logic [4:0]  shift_i,
    output logic [31:0] word_o,
    output logic        inexact_o
);

    logic [FP_EXP_W-1:0]  exp_base;
    logic [FP_EXP_W-1:0]  exp_fin;
    logic [FP_FRAC_W-1:0] frac;
    logic [FP_FRAC_W:0]   frac_sum;
    logic                 guard;
    logic                 sticky;
    logic                 round_up;
    logic                 unused_hidden;

    // Bit 31 is the implicit leading one and is dropped from the fraction.
    assign unused_hidden = mag_i[31];

    assign exp_base = FP_EXP_W'(FP_BIAS + 31) - {3'b000, shift_i};
    assign frac     = mag_i[30:8];
    assign guard    = mag_i[7];
    assign sticky   = |mag_i[6:0];
    assign round_up = guard & (sticky | frac[0]);

    // A carry out of the fraction leaves it all-zero and bumps the exponent;
    // the largest result exponent is 159, so infinity cannot occur.
    assign frac_sum = {1'b0, frac} + {{FP_FRAC_W{1'b0}}, round_up};
    assign exp_fin  = exp_base + {{(FP_EXP_W-1){1'b0}}, frac_sum[FP_FRAC_W]};

    assign word_o    = {sign_i, exp_fin, frac_sum[FP_FRAC_W-1:0]};
    assign inexact_o = guard | sticky;

endmodule

// File: rtl/int_to_float_seq.sv
// Sequential signed int32 -> IEEE-754 single converter: one-bit-per-cycle
// normalization followed by a single rounding/packing cycle.
module int_to_float_seq
    import int_to_float_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] in,
    output logic [31:0] out,
    output logic        busy,
    output logic        done,
    output logic        inexact,
    output logic [1:0]  dbg_state_o
);

    // Handshake: start is a request honoured only when the block is in IDLE
    // (busy=0); done is a one-cycle pulse qualifying out/inexact, which then
    // hold until the next conversion produces a result.

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [31:0] mag_q, mag_d;
    logic [4:0]  shift_q, shift_d;
    logic [31:0] out_q, out_d;
    logic        inexact_q, inexact_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [31:0] rp_word;
    logic        rp_inexact;

    fp_round_pack u_round_pack (
        .sign_i    (sign_q),
        .mag_i     (mag_q),
        .shift_i   (shift_q),
        .word_o    (rp_word),
        .inexact_o (rp_inexact)
    );

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        mag_d     = mag_q;
        shift_d   = shift_q;
        out_d     = out_q;
        inexact_d = inexact_q;
        done_d    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sign_d  = in[31];
                    // Negating 0x80000000 wraps back to 0x80000000, which is
                    // exactly the unsigned magnitude we want.
                    mag_d   = in[31] ? (~in + 32'd1) : in;
                    shift_d = 5'd0;
                    if (in == 32'd0) begin
                        out_d     = FP_POS_ZERO;
                        inexact_d = 1'b0;
                        state_d   = ST_DONE;
                    end else begin
                        state_d   = ST_NORMALIZE;
                    end
                end
            end
            ST_NORMALIZE: begin
                if (mag_q[31]) begin
                    state_d = ST_ROUND;
                end else begin
                    mag_d   = {mag_q[30:0], 1'b0};
                    shift_d = shift_q + 5'd1;
                end
            end
            ST_ROUND: begin
                out_d     = rp_word;
                inexact_d = rp_inexact;
                state_d   = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sign_q    <= 1'b0;
            mag_q     <= 32'd0;
            shift_q   <= 5'd0;
            out_q     <= 32'd0;
            inexact_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            mag_q     <= mag_d;
            shift_q   <= shift_d;
            out_q     <= out_d;
            inexact_q <= inexact_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign out         = out_q;
    assign inexact     = inexact_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_int_to_float_seq.sv
// Directed bench for int_to_float_seq: hand-computed conversions, latency,
// operand isolation and mid-conversion reset abort.
module tb_int_to_float_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] in;
    logic [31:0] out;
    logic        busy;
    logic        done;
    logic        inexact;
    logic [1:0]  dbg_state;

    int n_checks;
    int n_errs;
    int done_cnt;
    logic [31:0] exp_q[$];

    int_to_float_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in          (in),
        .out         (out),
        .busy        (busy),
        .done        (done),
        .inexact     (inexact),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // Applies one operand, scrambles `in` right after acceptance, waits for
    // done and checks result, flag, latency and the pulse width.
    task automatic convert(input logic [31:0] val, input logic [31:0] exp_out,
                           input logic exp_inex, input int exp_lat);
        int lat;
        logic [31:0] exp_word;
        exp_q.push_back(exp_out);
        @(negedge clk);
        in    = val;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        in    = $urandom;
        check("busy_after_accept", {31'd0, busy}, 32'd1);
        lat = 0;
        while (!done && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!done) begin
            check("done_timeout", {31'd0, done}, 32'd1);
            exp_q.delete();
        end else begin
            exp_word = exp_q.pop_front();
            check("latency", lat, exp_lat);
            check("out", out, exp_word);
            check("inexact", {31'd0, inexact}, {31'd0, exp_inex});
            @(posedge clk);
            #1;
            check("done_one_cycle", {31'd0, done}, 32'd0);
            check("out_held", out, exp_word);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int cnt0;
        n_checks = 0;
        n_errs   = 0;
        done_cnt = 0;
        reset    = 1'b1;
        start    = 1'b0;
        in       = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", out, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_inexact", {31'd0, inexact}, 32'd0);
        check("rst_state", {30'd0, dbg_state}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        convert(32'h0000_0001, 32'h3F80_0000, 1'b0, 34);
        convert(32'hFFFF_FFFF, 32'hBF80_0000, 1'b0, 34);
        convert(32'h0000_0000, 32'h0000_0000, 1'b0, 1);
        convert(32'h8000_0000, 32'hCF00_0000, 1'b0, 3);
        convert(32'h7FFF_FFFF, 32'h4F00_0000, 1'b1, 4);
        convert(32'h0100_0001, 32'h4B80_0000, 1'b1, 10);
        convert(32'h0100_0003, 32'h4B80_0002, 1'b1, 10);
        convert(32'hFFFF_FFFB, 32'hC0A0_0000, 1'b0, 32);

        // Abort: start in=1, re-pulse start with a new operand mid-flight,
        // then reset at cycle 10.
        cnt0 = done_cnt;
        @(negedge clk);
        in    = 32'h0000_0001;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        start = 1'b1;
        in    = 32'h1234_5678;
        @(posedge clk);
        #1;
        start = 1'b0;
        in    = 32'hDEAD_BEEF;
        repeat (6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_out", out, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_state", {30'd0, dbg_state}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("abort_no_done", done_cnt - cnt0, 32'd0);

        convert(32'h0000_0005, 32'h40A0_0000, 1'b0, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
        $finish;
    end

endmodule

// File: doc/int_to_float_seq.md
INT_TO_FLOAT_SEQ -- requirements
Module: int_to_float_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, listed first as: clk  input  1  rising-edge clock; reset  input  1  synchronous active-high reset.
REQ-002 The block SHALL have the port: start  input  1  request conversion of in; sampled only in IDLE.
REQ-003 The block SHALL have the port: in  input  32  signed two's-complement integer operand.
REQ-004 The block SHALL have the port: out  output  32  IEEE-754 single-precision result; held between conversions.
REQ-005 The block SHALL have the port: busy  output  1  high in every state except IDLE.
REQ-006 The block SHALL have the port: done  output  1  one-cycle pulse; out is valid in that cycle.
REQ-007 The block SHALL have the port: inexact  output  1  result was rounded; valid with done and held with out.

Function
REQ-008 The block SHALL use the states IDLE, NORMALIZE, ROUND and DONE, and SHALL register every output.
REQ-009 In IDLE with start=1, the block SHALL latch sign=in[31] and mag=|in| as an unsigned 32-bit value (0x80000000 gives mag 0x80000000), clear the shift count, and go to NORMALIZE.
REQ-010 In IDLE with start=1 and in==0, the block SHALL set out=0x00000000 and inexact=0 and go directly to DONE.
REQ-011 In NORMALIZE, each cycle the block SHALL go to ROUND if mag[31]=1; otherwise it SHALL shift mag left by 1 and increment the 5-bit shift count (at most 31 shifts).
REQ-012 In ROUND, the block SHALL compute exponent = 158 - shift count, fraction = mag[30:8], guard = mag[7] and sticky = OR of mag[6:0].
REQ-013 Rounding SHALL be round-to-nearest-even: increment the fraction when guard & (sticky | fraction[0]).
REQ-014 When fraction overflow occurs on rounding, the block SHALL set the fraction to 0 and increment the exponent; the maximum exponent is 159, so no infinity case exists.
REQ-015 In ROUND, the block SHALL set out = {sign, exponent[7:0], fraction} and inexact = guard | sticky, then go to DONE.
REQ-016 In DONE, the block SHALL hold done=1 for exactly one cycle and then return to IDLE.
REQ-017 Latency from the start sampling edge to done high SHALL be 1 cycle for zero input and 3 + shift-count cycles for nonzero input (minimum 3, maximum 34).
REQ-018 start SHALL be ignored while busy=1; in the DONE cycle, start is not accepted and must be reasserted in IDLE.
REQ-019 The in port SHALL be sampled only at acceptance; later changes to in SHALL NOT affect the result in flight.
REQ-020 out and inexact SHALL change only in ROUND, or on acceptance of a zero operand; otherwise they SHALL hold their value.

Reset
REQ-021 When reset=1 at a clock edge, the block SHALL force state to IDLE and set out=0, busy=0, done=0, inexact=0, mag=0 and shift count=0.
REQ-022 Reset SHALL take priority over start and SHALL abort any conversion in flight; no done pulse is produced for an aborted conversion.

Structure
REQ-023 The shared floating-point constants package SHALL hold the exponent bias (127), fraction width (23), exponent width (8), the state enum typedef, and the positive/negative zero constants.
REQ-024 The rounding-and-packing logic of REQ-012 to REQ-015 SHALL be one combinational sub-module, fp_round_pack, with inputs sign, mag and shift count and outputs packed word and inexact.
REQ-025 Normalization SHALL use exactly one 1-bit shift per cycle, with no combinational leading-zero counter, to keep the area small.

Verification
REQ-026 The bench SHALL apply in=0x00000001 -> out=0x3F800000, inexact=0, done 34 cycles after start.
REQ-027 The bench SHALL apply in=0xFFFFFFFF (-1) -> out=0xBF800000, inexact=0, and in=0x00000000 -> out=0x00000000, done 1 cycle after start.
REQ-028 The bench SHALL apply in=0x80000000 -> out=0xCF000000, inexact=0, done 3 cycles after start; and in=0x7FFFFFFF -> out=0x4F000000, inexact=1 (round-up mantissa carry).
REQ-029 The bench SHALL apply in=0x01000001 (tie) -> out=0x4B800000, inexact=1 (ties to even); and in=0x01000003 -> out=0x4B800002, inexact=1 (tie, rounds up).
REQ-030 The bench SHALL start in=0x00000001, pulse start again and change in during NORMALIZE, then assert reset at cycle 10 -> no done, busy=0 and out=0 next cycle; a following start with in=5 -> out=0x40A00000.
